// File: rtl/nibble_serial_adder_if.sv
// Requester-side bundle for nibble_serial_adder: start/busy/done handshake,
// operands, and the registered result with its carry and overflow flags.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  // Request side
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;

  // Result side
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // The requester drives operands and sees the result.
  modport master (
    output start,
    output a,
    output b,
    output cin,
    output sub,
    input  busy,
    input  done,
    input  sum,
    input  cout,
    input  ovf
  );

  // The sequencer samples operands and drives the result.
  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    input  sub,
    output busy,
    output done,
    output sum,
    output cout,
    output ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W = 4*NIBBLES bit adder/subtractor built around one 4-bit
// adder slice. One nibble per clock, least-significant first, with a
// registered carry chaining the passes. Subtraction is A + ~B + 1 - cin.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastK = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;       // already inverted for subtraction
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [CntW-1:0] r_k;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_ovf;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_s;
  logic            w_cy;
  logic [W-1:0]    w_sum_next;
  logic            w_last;
  logic            w_ovf;

  // Select the current nibble of each operand and merge the slice result
  // into the running sum; constant part-selects keep every index in range.
  always_comb begin
    w_a_nib    = 4'h0;
    w_b_nib    = 4'h0;
    w_s        = 4'h0;
    w_cy       = 1'b0;
    w_sum_next = r_sum;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (r_k == CntW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
    // The shared 4-bit adder slice.
    {w_cy, w_s} = 5'(w_a_nib) + 5'(w_b_nib) + 5'(r_carry);
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (r_k == CntW'(i)) begin
        w_sum_next[4*i +: 4] = w_s;
      end
    end
    w_last = (r_k == LastK);
    // Signed overflow: like-signed operands producing an opposite-signed result.
    w_ovf  = (r_a[W-1] == r_b[W-1]) && (w_sum_next[W-1] != r_a[W-1]);
  end

  // Sequencer FSM with registered handshake and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            // Two's-complement +1 for subtract, minus the borrow-in.
            r_carry <= bus.cin ^ bus.sub;
            r_k     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cy;
          if (w_last) begin
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_cy;
            r_ovf   <= w_ovf;
            r_state <= StDone;
          end else begin
            r_k <= r_k + CntW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
